// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: word/index types, the
// write-register/requester bundle and the bypass/stall index compare.
package rf_write_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regBits;

  typedef struct packed {
    logic   en;
    regBits idx;
    word_t  data;
  } rf_wr_t;

  // x0 is hard-wired, so it never matches for forwarding or hazard purposes
  function automatic logic idx_hit(input logic en, input regBits a, input regBits b);
    return en && (a == b) && (a != '0);
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requesters, decode read indices and register-file write port.
interface rf_write_arbiter_if #(parameter int DATA_W = 32, parameter int IDX_W = 5);
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [IDX_W-1:0]  a_index, b_index;
  logic [DATA_W-1:0] a_data, b_data;
  logic [IDX_W-1:0]  read_index1, read_index2;
  logic              bypass_valid1, bypass_valid2, stall1, stall2;
  logic [DATA_W-1:0] bypass_data1, bypass_data2;
  logic              reg_write;
  logic [IDX_W-1:0]  write_index;
  logic [DATA_W-1:0] write_data;

  modport master (
    output a_valid, a_index, a_data, b_valid, b_index, b_data, read_index1, read_index2,
    input  a_ready, b_ready, bypass_valid1, bypass_valid2, bypass_data1, bypass_data2,
           stall1, stall2, reg_write, write_index, write_data
  );
  modport slave (
    input  a_valid, a_index, a_data, b_valid, b_index, b_data, read_index1, read_index2,
    output a_ready, b_ready, bypass_valid1, bypass_valid2, bypass_data1, bypass_data2,
           stall1, stall2, reg_write, write_index, write_data
  );
  modport rf (input reg_write, write_index, write_data);
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant; reusable for any shared single-port resource.
module rf_write_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       nRst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;  // 0: port 0 won last, 1: port 1 won last

  always_comb begin
    gnt = '0;
    if (nRst) begin
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)       last <= 1'b1;
    else if (gnt[0]) last <= 1'b0;
    else if (gnt[1]) last <= 1'b1;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin share of the register-file write port between ALU (A) and load
// (B) writeback, with a one-stage write register plus decode bypass/stall.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = $bits(word_t),
  parameter int IDX_W  = $bits(regBits)
) (
  input logic clk,
  input logic nRst,
  rf_write_arbiter_if.slave bus
);
  localparam int NUM_RD = 2;

  logic [1:0] gnt;
  rf_wr_t     a_req, b_req, win, los, wr_q;
  logic       win_vld, los_vld;

  logic [NUM_RD-1:0][IDX_W-1:0]  rd_idx;
  logic [NUM_RD-1:0]             byp_vld, stall;
  logic [NUM_RD-1:0][DATA_W-1:0] byp_data;

  assign a_req = '{en: bus.a_valid, idx: bus.a_index, data: bus.a_data};
  assign b_req = '{en: bus.b_valid, idx: bus.b_index, data: bus.b_data};

  rf_write_arbiter_rr_arb2 u_arb (
    .clk  (clk),
    .nRst (nRst),
    .req  ({bus.b_valid, bus.a_valid}),
    .gnt  (gnt)
  );

  // A loser only exists when someone actually won this cycle
  assign win     = gnt[1] ? b_req : a_req;
  assign los     = gnt[1] ? a_req : b_req;
  assign win_vld = |gnt;
  assign los_vld = los.en && win_vld;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_q <= '0;
    end else begin
      wr_q.en <= win_vld && (win.idx != '0);
      if (win_vld) begin
        wr_q.idx  <= win.idx;
        wr_q.data <= win.data;
      end
    end
  end

  assign rd_idx = {bus.read_index2, bus.read_index1};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign byp_vld[k]  = idx_hit(wr_q.en, wr_q.idx, rd_idx[k]);
    assign byp_data[k] = byp_vld[k] ? wr_q.data : '0;
    // winner's data only reaches the write register next cycle, so it stalls too
    assign stall[k]    = idx_hit(los_vld, los.idx, rd_idx[k]) |
                         idx_hit(win_vld, win.idx, rd_idx[k]);
  end

  assign bus.a_ready       = gnt[0];
  assign bus.b_ready       = gnt[1];
  assign bus.reg_write     = wr_q.en;
  assign bus.write_index   = wr_q.idx;
  assign bus.write_data    = wr_q.data;
  assign bus.bypass_valid1 = byp_vld[0];
  assign bus.bypass_valid2 = byp_vld[1];
  assign bus.bypass_data1  = byp_data[0];
  assign bus.bypass_data2  = byp_data[1];
  assign bus.stall1        = stall[0];
  assign bus.stall2        = stall[1];
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between two writeback requesters: A (execute/ALU result) and B (memory load return). It arbitrates round-robin and registers the winning write into a one-stage write register that drives the register file's `reg_write`, `write_index` and `write_data` inputs. It also exposes bypass data and stall flags so the decode stage can read values that are still in flight. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `DATA_W`, 32, write data width; equals `word_t`.
- `IDX_W`, 5, register index width; equals `regBits`.

Ports (clock and reset first):
- `clk` in 1 — single clock; all state changes on the rising edge.
- `nRst` in 1 — reset, asynchronous, active-low.
- `a_valid` in 1 — requester A has a write pending.
- `a_index` in IDX_W — destination register for A.
- `a_data` in DATA_W — write data for A.
- `a_ready` out 1 — A's request is accepted this cycle.
- `b_valid`, `b_index`, `b_data`, `b_ready` — same as the four A ports, for requester B.
- `read_index1`, `read_index2` in IDX_W — the decode stage's source registers.
- `bypass_valid1`, `bypass_valid2` out 1 — the write register holds the newest value for the matching read index.
- `bypass_data1`, `bypass_data2` out DATA_W — the bypass value.
- `stall1`, `stall2` out 1 — a pending request that lost arbitration targets the matching read index.
- `reg_write` out 1 — drives the register file write enable.
- `write_index` out IDX_W — drives the register file write index.
- `write_data` out DATA_W — drives the register file write data.

## Operation
- **Accept rule:** a request is accepted in a cycle when its `valid` and its `ready` are both high.
- **`ready` is combinational from `valid` and the `last` bit:**
  - Only A valid: `a_ready=1`.
  - Only B valid: `b_ready=1`.
  - Both valid: grant the requester not granted last. `last=0` means A was granted last, so B wins; `last=1` means A wins.
  - Neither valid: both `ready` low.
- **`last` update:** `last` updates only on an accepted grant (0 = A granted, 1 = B granted). It holds when idle.
- **Index 0:** an accepted request with index 0 is consumed (its `ready` is high) but loads `reg_write=0` into the write register. `last` still updates.
- **Write register:** every cycle it loads the accepted request, or `reg_write=0` if nothing was accepted. `write_index` and `write_data` are loaded from the winner; they hold their previous value when nothing is accepted.
- **Bypass:** `bypass_validk = reg_write && read_indexk==write_index && read_indexk!=0`. `bypass_datak = write_data` whenever `bypass_validk=1`, else 0.
- **Stall:**
  - `stallk` = the losing requester is valid, its index equals `read_indexk`, and that index is nonzero.
  - `stallk` is also raised when the winning request this cycle matches `read_indexk` (nonzero index). Its data is not readable until the next cycle.
- **Same destination from A and B in one cycle:** both are granted in round-robin order over two cycles. The later write wins. Ordering between A and B is the requesters' responsibility.

## Timing
- **Reset values:** `reg_write=0`, `write_index=0`, `write_data=0`, `last=1` (A wins the first tie).
- **Reset is asynchronous:** asserting `nRst` mid-operation clears everything immediately. Any in-flight write is dropped.
- **While `nRst` is low:** `a_ready` and `b_ready` are forced to 0.
- **Latency:** a request accepted at edge N drives the register file during cycle N+1; the file commits it at edge N+2 (one cycle after it appears on the write port).
- **Throughput:** one write per cycle. A continuously valid requester waits at most one cycle under contention.
- **`valid` rule:** a requester must hold `valid`, `index` and `data` stable until `ready`. `valid` may not drop before acceptance.
- **Combinational paths:** `ready`, `bypass` and `stall` are combinational from the current-cycle inputs and registered state. There is no combinational path from `ready` back to `valid`.

## Structure
- **`cpu_pkg`:** uses `word_t` and `regBits`. Add `typedef struct packed {logic en; regBits idx; word_t data;} rf_wr_t` for the write-register contents and requester bundles.
- **Sub-module `rr_arb2`:** a two-way round-robin grant with its `last` register. It is reusable for other shared ports.
- **Top level:** holds the write register plus the bypass and stall compare logic.
- **Interface:** the outputs connect directly to the register file interface. A new `arb` modport drives `reg_write`, `write_index` and `write_data`.

## Test plan
- **Reset:** hold `nRst=0` with both `valid` high → all outputs 0, both `ready` 0. Release → the first tie grants A.
- **Single request:** A only, idx 5, data 0xDEADBEEF → `a_ready=1` in cycle 0. Cycle 1: `reg_write=1`, `write_index=5`, `write_data=0xDEADBEEF`. Cycle 2: `reg_write=0`.
- **Contention:** both valid for 4 cycles (A idx 1..., B idx 2...) → grants alternate A, B, A, B, and the write port shows 1, 2, 1, 2 one cycle later.
- **x0:** B writes idx 0 with data 0x1234 → `b_ready=1`, `reg_write` stays 0, and `bypass_valid` stays 0 even with `read_index1=0`.
- **Bypass and stall:** A idx 7 accepted with `read_index1=7` → `stall1=1` in that cycle. Next cycle: `bypass_valid1=1`, `bypass_data1` = A's data. A losing B with idx 9 and `read_index2=9` → `stall2=1`.
- **Reset mid-operation:** pull `nRst` low while `reg_write=1` → `reg_write=0` immediately, without waiting for an edge. After release, no stale write appears.
